// File: rtl/digest_checker.sv
// digest_checker: loads a 4-byte message and a 4-byte expected digest, runs the hash core, and reports match/timeout
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_data      : byte stream in (4 message bytes, then 4 expected-digest bytes, MSB first)
//   in_ready              : byte accepted this cycle when in_valid is also high
//   core_start/core_msg   : one-cycle start pulse and message word to the hash core
//   core_done/core_digest : completion pulse and digest from the hash core
//   res_valid/res_ready   : result handshake
//   res_match/res_err     : digest matched / hash core timed out
//   res_digest            : captured digest (0 on timeout)
//   pass_cnt              : saturating count of matching results
module digest_checker #(
  parameter logic [7:0] TIMEOUT = 8'd100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        core_start,
  output logic [31:0] core_msg,
  input  logic        core_done,
  input  logic [31:0] core_digest,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_match,
  output logic        res_err,
  output logic [31:0] res_digest,
  output logic [7:0]  pass_cnt
);
  typedef enum logic [1:0] {LOAD, START, WAIT, RESULT} state_t;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] timer_q, timer_d, pass_q, pass_d;
  logic [31:0] msg_q, msg_d, exp_q, exp_d, dig_q, dig_d;
  logic match_q, match_d, err_q, err_d;
  logic acc;
  logic [1:0] pos;
  assign in_ready = state_q == LOAD && !rst;
  assign acc = in_valid && in_ready;
  // byte index 0..3 within a word maps to bit offset 24,16,8,0
  assign pos = ~idx_q[1:0];
  assign core_start = state_q == START;
  assign core_msg = msg_q;
  assign res_valid = state_q == RESULT;
  assign res_match = match_q;
  assign res_err = err_q;
  assign res_digest = dig_q;
  assign pass_cnt = pass_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    timer_d = timer_q;
    pass_d = pass_q;
    msg_d = msg_q;
    exp_d = exp_q;
    dig_d = dig_q;
    match_d = match_q;
    err_d = err_q;
    case (state_q)
      LOAD: if (acc) begin
        idx_d = idx_q + 3'd1;
        if (idx_q[2]) exp_d[{pos, 3'b000} +: 8] = in_data;
        else msg_d[{pos, 3'b000} +: 8] = in_data;
        if (idx_q == 3'd7) state_d = START;
      end
      START: begin
        state_d = WAIT;
        timer_d = 8'd0;
      end
      WAIT: if (core_done) begin
        dig_d = core_digest;
        match_d = core_digest == exp_q;
        err_d = 1'b0;
        pass_d = (core_digest == exp_q && pass_q != 8'hff) ? pass_q + 8'd1 : pass_q;
        state_d = RESULT;
      end else if (timer_q == TIMEOUT - 8'd1) begin
        dig_d = 32'd0;
        match_d = 1'b0;
        err_d = 1'b1;
        state_d = RESULT;
      end else begin
        timer_d = timer_q + 8'd1;
      end
      RESULT: state_d = res_ready ? LOAD : RESULT;
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      idx_q <= 3'd0;
      timer_q <= 8'd0;
      pass_q <= 8'd0;
      msg_q <= 32'd0;
      exp_q <= 32'd0;
      dig_q <= 32'd0;
      match_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      timer_q <= timer_d;
      pass_q <= pass_d;
      msg_q <= msg_d;
      exp_q <= exp_d;
      dig_q <= dig_d;
      match_q <= match_d;
      err_q <= err_d;
    end
  end
endmodule

// File: doc/digest_checker.md
DIGEST_CHECKER -- requirements
Module: digest_checker

Interface
REQ-001 Parameter TIMEOUT, default 8'd100: the maximum number of WAIT cycles allowed for core_done before an error result.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  the upstream byte on in_data is valid.
REQ-005 in_data  input  8  byte stream: 4 message bytes, then 4 expected-digest bytes, MSB first.
REQ-006 in_ready  output  1  the block accepts a byte this cycle.
REQ-007 core_start  output  1  one-cycle start pulse to the hash core.
REQ-008 core_msg  output  32  message word presented to the hash core.
REQ-009 core_done  input  1  completion pulse from the hash core.
REQ-010 core_digest  input  32  hash core digest {A,B,C,D}, valid while core_done=1.
REQ-011 res_valid  output  1  a result is available.
REQ-012 res_ready  input  1  downstream accepts the result.
REQ-013 res_match  output  1  captured digest equals the expected digest.
REQ-014 res_err  output  1  the hash core timed out.
REQ-015 res_digest  output  32  captured core digest; 0 on timeout.
REQ-016 pass_cnt  output  8  number of matching results, saturating.

Function
REQ-017 The FSM SHALL have the states LOAD, START, WAIT and RESULT; it SHALL be in LOAD after reset.
REQ-018 in_ready SHALL be 1 only in LOAD and 0 while rst is high; a byte SHALL be accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-019 The 3-bit byte index 0..3 SHALL load msg[31:24], msg[23:16], msg[15:8], msg[7:0] in order; index 4..7 SHALL load exp[31:24]..exp[7:0] in order.
REQ-020 in_valid gaps SHALL stall the byte index without loss; bytes with in_ready=0 SHALL be ignored.
REQ-021 Accepting index 7 SHALL move the FSM LOAD->START and wrap the index to 0.
REQ-022 In START, core_start SHALL be 1 for exactly one cycle, and the FSM SHALL then move to WAIT with the 8-bit timer cleared.
REQ-023 core_msg SHALL equal the msg register at all times; msg SHALL change only during LOAD byte acceptance.
REQ-024 In WAIT, core_done=1 SHALL capture core_digest into res_digest, set res_match=(core_digest==exp), set res_err=0, and move to RESULT.
REQ-025 In WAIT, the timer SHALL increment every cycle without core_done; when timer==TIMEOUT-1, the FSM SHALL set res_err=1, res_match=0, res_digest=0 and move to RESULT.
REQ-026 If core_done and the timeout condition coincide, core_done SHALL take priority.
REQ-027 core_done outside WAIT SHALL be ignored.
REQ-028 In RESULT, res_valid SHALL be 1 and res_match, res_err and res_digest SHALL be stable; res_ready=1 SHALL move the FSM to LOAD.
REQ-029 in_ready SHALL go high no earlier than the cycle after the res_ready handshake.
REQ-030 pass_cnt SHALL increment by 1 when a result is entered with res_match=1, and SHALL hold at 255.
REQ-031 Latency from index-7 acceptance (edge N): core_start SHALL be high in cycle N+1; res_valid SHALL rise on the edge after the edge on which core_done=1 is sampled.

Reset
REQ-032 Asserting rst SHALL immediately force state=LOAD, byte index=0, timer=0, msg=0, exp=0, core_start=0, res_valid=0, res_match=0, res_err=0, res_digest=0 and pass_cnt=0, in any state including mid-WAIT.
REQ-033 After reset release, the first accepted byte SHALL be treated as index 0.

Verification
REQ-034 Bytes 0A 0B 0C 0D 12 34 56 78, core model returning done with 0x12345678 after 66 cycles -> core_start pulse, core_msg=0x0A0B0C0D, res_valid, res_match=1, res_err=0, pass_cnt=1.
REQ-035 Same bytes, core returns 0x12345679 -> res_match=0, res_digest=0x12345679, pass_cnt unchanged.
REQ-036 core_done never asserted -> res_valid exactly TIMEOUT cycles after entering WAIT with res_err=1, res_match=0, res_digest=0.
REQ-037 in_valid toggling every other cycle and res_ready held low for 10 cycles -> all bytes assembled correctly, result outputs stable for all 10 cycles, in_ready=0 throughout.
REQ-038 rst pulsed during WAIT, then a spurious core_done in LOAD, then a full transaction -> spurious done ignored, outputs cleared, new transaction correct.
REQ-039 256 matching transactions -> pass_cnt saturates at 255.
